// File: rtl/vend_ctrl_multi.sv
// Multi-product vending controller: coin credit, priced multi-cup orders, brewer
// handshake and greedy change paid from tracked per-denomination coin tubes.
module vend_ctrl_multi #(
  parameter int NUM_PROD = 4,
  parameter int CREDIT_W = 8,
  parameter int MAX_CUPS = 5,
  parameter int TUBE_W   = 6,
  localparam int PW = (NUM_PROD > 1) ? $clog2(NUM_PROD) : 1,
  localparam int CW = $clog2(MAX_CUPS + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [3:0]          coin_in,
  output logic                coin_reject,
  input  logic [PW-1:0]       sel_prod,
  input  logic [CW-1:0]       sel_cups,
  input  logic                confirm,
  input  logic                cancel,
  input  logic                manage,
  input  logic                price_we,
  input  logic [PW-1:0]       price_idx,
  input  logic [CREDIT_W-1:0] price_data,
  input  logic                tube_we,
  input  logic [1:0]          tube_idx,
  input  logic [TUBE_W-1:0]   tube_data,
  output logic                make_start,
  output logic [PW-1:0]       make_prod,
  output logic [CW-1:0]       make_cups,
  input  logic                make_done,
  input  logic                take_out,
  output logic [3:0]          ret_coin,
  output logic [CREDIT_W-1:0] credit,
  output logic                insufficient,
  output logic                change_short,
  output logic                busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_CREDIT, S_CHECK, S_MAKING, S_WAIT_TAKE, S_CHANGE, S_MANAGE
  } state_t;

  localparam int COST_W = CREDIT_W + CW;

  state_t              state;
  logic [CREDIT_W-1:0] price [2**PW];
  logic [TUBE_W-1:0]   tube  [4];     // index 0..3 = 50, 100, 500, 1000 won
  logic [PW-1:0]       req_prod;
  logic [CW-1:0]       req_cups;

  // Coin weights in units of 50 won, indexed like coin_in / tube.
  function automatic logic [4:0] weight(input logic [1:0] d);
    case (d)
      2'd0:    weight = 5'd1;
      2'd1:    weight = 5'd2;
      2'd2:    weight = 5'd10;
      default: weight = 5'd20;
    endcase
  endfunction

  logic [1:0]          coin_idx;
  logic                coin_any, coin_multi, coin_ovf;
  logic [CREDIT_W:0]   credit_sum;
  logic [COST_W-1:0]   cost;
  logic                req_ok;
  logic                chg_ok;
  logic [1:0]          chg_idx;
  logic [CREDIT_W-1:0] chg_w;

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    coin_idx = 2'd0;
    for (int i = 0; i < 4; i++)
      if (coin_in[i]) coin_idx = 2'(i);
  end

  assign coin_any   = |coin_in;
  assign coin_multi = (coin_in & (coin_in - 4'd1)) != 4'd0;
  assign credit_sum = {1'b0, credit} + (CREDIT_W+1)'(weight(coin_idx));
  assign coin_ovf   = credit_sum[CREDIT_W];

  assign cost   = COST_W'(price[req_prod]) * COST_W'(req_cups);
  assign req_ok = (req_cups != '0) && (int'(req_cups) <= MAX_CUPS) &&
                  (int'(req_prod) < NUM_PROD);

  // Ascending scan: the last payable denomination found is the largest one.
  // NOTE: blocking assignments here are combinational temporaries; registers use <=.
  always_comb begin
    chg_ok  = 1'b0;
    chg_idx = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (tube[i] != '0 && CREDIT_W'(weight(2'(i))) <= credit) begin
        chg_ok  = 1'b1;
        chg_idx = 2'(i);
      end
    end
  end
  assign chg_w = CREDIT_W'(weight(chg_idx));

  assign busy = !(state == S_IDLE || state == S_CREDIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      credit       <= '0;
      coin_reject  <= 1'b0;
      insufficient <= 1'b0;
      make_start   <= 1'b0;
      make_prod    <= '0;
      make_cups    <= '0;
      ret_coin     <= '0;
      change_short <= 1'b0;
      req_prod     <= '0;
      req_cups     <= '0;
      // NOTE: the price and tube tables are small register arrays and are cleared
      // on reset; a RAM macro would not allow this.
      for (int i = 0; i < 2**PW; i++) price[i] <= '0;
      for (int i = 0; i < 4; i++)     tube[i]  <= '0;
    end else begin
      coin_reject  <= coin_any;
      insufficient <= 1'b0;
      make_start   <= 1'b0;
      ret_coin     <= '0;

      case (state)
        S_IDLE, S_CREDIT: begin
          if (manage && credit == '0) begin
            state <= S_MANAGE;
          end else begin
            if (coin_any) begin
              coin_reject <= coin_multi || coin_ovf;
              if (!coin_ovf) begin
                credit       <= credit_sum[CREDIT_W-1:0];
                change_short <= 1'b0;
                if (tube[coin_idx] != '1) tube[coin_idx] <= tube[coin_idx] + TUBE_W'(1);
                state <= S_CREDIT;
              end
            end
            // Cancel and confirm see the credit including a coin taken this cycle.
            if (state == S_CREDIT) begin
              if (cancel) begin
                state <= S_CHANGE;
              end else if (confirm) begin
                req_prod <= sel_prod;
                req_cups <= sel_cups;
                state    <= S_CHECK;
              end
            end
          end
        end

        S_CHECK: begin
          if (!req_ok || cost > COST_W'(credit)) begin
            insufficient <= 1'b1;
            state        <= S_CREDIT;
          end else begin
            credit     <= credit - cost[CREDIT_W-1:0];
            make_prod  <= req_prod;
            make_cups  <= req_cups;
            make_start <= 1'b1;
            state      <= S_MAKING;
          end
        end

        S_MAKING:    if (make_done) state <= S_WAIT_TAKE;

        S_WAIT_TAKE: if (take_out) state <= (credit != '0) ? S_CHANGE : S_IDLE;

        S_CHANGE: begin
          if (credit == '0) begin
            state <= S_IDLE;
          end else if (chg_ok) begin
            ret_coin      <= 4'b0001 << chg_idx;
            credit        <= credit - chg_w;
            tube[chg_idx] <= tube[chg_idx] - TUBE_W'(1);
            if (credit == chg_w) state <= S_IDLE;
          end else begin
            change_short <= 1'b1;
            state        <= S_CREDIT;
          end
        end

        S_MANAGE: begin
          if (price_we) price[price_idx] <= price_data;
          if (tube_we)  tube[tube_idx]   <= tube_data;
          if (!manage)  state <= S_IDLE;
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vend_ctrl_multi.sv
// Self-checking bench for vend_ctrl_multi: directed scenarios plus randomized
// operations compared against a transaction-level credit/tube model.
module tb_vend_ctrl_multi;

  localparam int NUM_PROD = 4;
  localparam int CREDIT_W = 8;
  localparam int MAX_CUPS = 5;
  localparam int TUBE_W   = 6;
  localparam int PW       = 2;
  localparam int CW       = 3;
  localparam int CREDIT_MAX = 255;
  localparam int TUBE_MAX   = 63;

  logic                clk = 1'b0;
  logic                rst_n = 1'b0;
  logic [3:0]          coin_in = '0;
  logic                coin_reject;
  logic [PW-1:0]       sel_prod = '0;
  logic [CW-1:0]       sel_cups = '0;
  logic                confirm = 1'b0, cancel = 1'b0, manage = 1'b0;
  logic                price_we = 1'b0;
  logic [PW-1:0]       price_idx = '0;
  logic [CREDIT_W-1:0] price_data = '0;
  logic                tube_we = 1'b0;
  logic [1:0]          tube_idx = '0;
  logic [TUBE_W-1:0]   tube_data = '0;
  logic                make_start;
  logic [PW-1:0]       make_prod;
  logic [CW-1:0]       make_cups;
  logic                make_done = 1'b0, take_out = 1'b0;
  logic [3:0]          ret_coin;
  logic [CREDIT_W-1:0] credit;
  logic                insufficient, change_short, busy;

  always #5 clk = ~clk;

  vend_ctrl_multi #(.NUM_PROD(NUM_PROD), .CREDIT_W(CREDIT_W), .MAX_CUPS(MAX_CUPS),
                    .TUBE_W(TUBE_W)) dut (
    .clk(clk), .rst_n(rst_n), .coin_in(coin_in), .coin_reject(coin_reject),
    .sel_prod(sel_prod), .sel_cups(sel_cups), .confirm(confirm), .cancel(cancel),
    .manage(manage), .price_we(price_we), .price_idx(price_idx), .price_data(price_data),
    .tube_we(tube_we), .tube_idx(tube_idx), .tube_data(tube_data),
    .make_start(make_start), .make_prod(make_prod), .make_cups(make_cups),
    .make_done(make_done), .take_out(take_out), .ret_coin(ret_coin), .credit(credit),
    .insufficient(insufficient), .change_short(change_short), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: machine credit, price table, tube contents, shortage flag.
  int m_credit;
  int m_price [4];
  int m_tube  [4];
  int m_short;
  int weight_of [4] = '{1, 2, 10, 20};

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset;
    m_credit = 0;
    m_short  = 0;
    for (int i = 0; i < 4; i++) begin
      m_price[i] = 0;
      m_tube[i]  = 0;
    end
  endtask

  task automatic do_coin(input logic [3:0] bits);
    int idx, w, multi;
    idx = 0;
    for (int i = 0; i < 4; i++) if (bits[i]) idx = i;
    multi = ($countones(bits) > 1) ? 1 : 0;
    w = weight_of[idx];
    coin_in = bits;
    tick;
    coin_in = '0;
    if (m_credit + w > CREDIT_MAX) begin
      check("coin_reject_ovf", coin_reject, 1);
    end else begin
      m_credit += w;
      if (m_tube[idx] < TUBE_MAX) m_tube[idx]++;
      m_short = 0;
      check("coin_reject", coin_reject, multi);
    end
    check("coin_credit", credit, m_credit);
    check("coin_busy", busy, 0);
    check("coin_short", change_short, m_short);
  endtask

  // Greedy payout computed from the model, then matched pulse by pulse.
  task automatic collect_change(input string tag);
    int exp_q[$];
    int d, got_n, done;
    while (m_credit > 0) begin
      d = -1;
      for (int i = 0; i < 4; i++)
        if (m_tube[i] > 0 && weight_of[i] <= m_credit) d = i;
      if (d < 0) begin
        m_short = 1;
        break;
      end
      exp_q.push_back(d);
      m_credit -= weight_of[d];
      m_tube[d]--;
    end
    got_n = 0;
    done  = 0;
    for (int c = 0; c < 40 && done == 0; c++) begin
      tick;
      if (ret_coin != 4'd0) begin
        if (got_n < exp_q.size()) check({tag, "_coin"}, ret_coin, 1 << exp_q[got_n]);
        else                      check({tag, "_extra_coin"}, ret_coin, 0);
        got_n++;
      end
      if (!busy) done = 1;
    end
    check({tag, "_timeout"}, done, 1);
    check({tag, "_ncoins"}, got_n, exp_q.size());
    check({tag, "_credit"}, credit, m_credit);
    check({tag, "_short"}, change_short, m_short);
  endtask

  task automatic do_buy(input int prod, input int cups, input int poke);
    int cost, ok;
    sel_prod = PW'(prod);
    sel_cups = CW'(cups);
    confirm  = 1'b1;
    tick;
    confirm  = 1'b0;
    check("check_busy", busy, 1);
    tick;
    cost = m_price[prod] * cups;
    ok = (cups >= 1 && cups <= MAX_CUPS && cost <= m_credit) ? 1 : 0;
    check("insufficient", insufficient, 1 - ok);
    check("make_start", make_start, ok);
    if (ok == 0) begin
      check("insuf_credit", credit, m_credit);
      check("insuf_busy", busy, 0);
      return;
    end
    m_credit -= cost;
    check("buy_credit", credit, m_credit);
    check("make_prod", make_prod, prod);
    check("make_cups", make_cups, cups);
    check("making_busy", busy, 1);
    if (poke != 0) begin
      coin_in = 4'b0100;
      cancel  = 1'b1;
      tick;
      coin_in = '0;
      cancel  = 1'b0;
      check("busy_coin_reject", coin_reject, 1);
      check("busy_coin_credit", credit, m_credit);
      check("make_start_once", make_start, 0);
      check("cancel_ignored", busy, 1);
    end
    make_done = 1'b1;
    tick;
    make_done = 1'b0;
    check("wait_take_busy", busy, 1);
    take_out = 1'b1;
    tick;
    take_out = 1'b0;
    if (m_credit > 0) begin
      collect_change("buy_chg");
    end else begin
      check("buy_idle", busy, 0);
      check("buy_no_ret", ret_coin, 0);
    end
  endtask

  task automatic do_cancel(input int with_confirm);
    cancel   = 1'b1;
    confirm  = with_confirm[0];
    sel_prod = '0;
    sel_cups = 3'd1;
    tick;
    cancel  = 1'b0;
    confirm = 1'b0;
    check("cancel_busy", busy, 1);
    collect_change("cancel");
  endtask

  task automatic enter_manage;
    manage = 1'b1;
    tick;
    check("manage_busy", busy, 1);
  endtask

  task automatic write_price(input int idx, input int data);
    price_we = 1'b1; price_idx = PW'(idx); price_data = CREDIT_W'(data);
    tick;
    price_we = 1'b0;
    m_price[idx] = data;
  endtask

  task automatic write_tube(input int idx, input int data);
    tube_we = 1'b1; tube_idx = 2'(idx); tube_data = TUBE_W'(data);
    tick;
    tube_we = 1'b0;
    m_tube[idx] = data;
  endtask

  task automatic exit_manage;
    manage  = 1'b0;
    coin_in = 4'b0010;
    tick;
    coin_in = '0;
    check("manage_coin_reject", coin_reject, 1);
    check("manage_exit_busy", busy, 0);
    check("manage_credit", credit, 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bits;
    int r;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_credit", credit, 0);
    check("rst_busy", busy, 0);
    check("rst_ret", ret_coin, 0);
    check("rst_make_start", make_start, 0);
    check("rst_make_prod", make_prod, 0);
    check("rst_make_cups", make_cups, 0);
    check("rst_coin_reject", coin_reject, 0);
    check("rst_insufficient", insufficient, 0);
    check("rst_short", change_short, 0);
    rst_n = 1'b1;
    tick;

    // Prices and a simple purchase with exact credit.
    enter_manage();
    write_price(0, 6);
    write_price(1, 7);
    write_price(3, 9);
    exit_manage();
    do_coin(4'b0010);
    do_coin(4'b0100);
    do_buy(0, 2, 1);

    // Change 13 from tubes {1000:0, 500:1, 100:2, 50:5}.
    enter_manage();
    write_tube(0, 5);
    write_tube(1, 2);
    write_tube(2, 1);
    write_tube(3, 0);
    exit_manage();
    do_coin(4'b1000);
    do_buy(1, 1, 0);

    // Overflow rejection, multi-coin collision, then refund with confirm colliding.
    repeat (12) do_coin(4'b1000);
    do_coin(4'b0100);
    do_coin(4'b1000);
    do_coin(4'b0011);
    do_cancel(1);

    // Cup-count limit against a freshly written price.
    repeat (4) do_coin(4'b0010);
    do_coin(4'b0001);
    do_buy(3, 6, 0);
    do_buy(3, 0, 0);
    do_buy(3, 1, 1);

    // Unpayable change leaves residual credit and a sticky shortage flag.
    enter_manage();
    for (int i = 0; i < 4; i++) write_tube(i, 0);
    exit_manage();
    do_coin(4'b0100);
    do_buy(1, 1, 0);
    do_cancel(0);
    do_coin(4'b0001);

    // Reset asserted while change is being paid.
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    tick;
    check("pre_rst_ret", ret_coin, 4'b0001);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_ret", ret_coin, 0);
    check("midrst_credit", credit, 0);
    check("midrst_busy", busy, 0);
    check("midrst_short", change_short, 0);
    #1 rst_n = 1'b1;
    model_reset();
    tick;
    check("postrst_busy", busy, 0);
    check("postrst_credit", credit, 0);

    // Randomized operation mix.
    enter_manage();
    for (int i = 0; i < 4; i++) write_price(i, $urandom_range(0, 40));
    for (int i = 0; i < 4; i++) write_tube(i, $urandom_range(0, TUBE_MAX));
    exit_manage();
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 99);
      if ($urandom_range(0, 3) != 0) bits = 4'b0001 << $urandom_range(0, 3);
      else                           bits = 4'($urandom_range(1, 15));
      if (r < 45) begin
        do_coin(bits);
      end else if (r < 75) begin
        if (m_credit > 0) do_buy($urandom_range(0, 3), $urandom_range(0, 7), $urandom_range(0, 1));
        else              do_coin(bits);
      end else if (r < 88) begin
        if (m_credit > 0) do_cancel($urandom_range(0, 1));
        else              do_coin(bits);
      end else begin
        if (m_credit == 0) begin
          enter_manage();
          repeat ($urandom_range(1, 3)) begin
            if ($urandom_range(0, 1) == 1) write_price($urandom_range(0, 3), $urandom_range(0, 40));
            else                           write_tube($urandom_range(0, 3), $urandom_range(0, TUBE_MAX));
          end
          exit_manage();
        end else begin
          do_coin(bits);
        end
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
